pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage ARM pipeline. It combines the hazard-unit stall, the EXE-stage taken-branch signal and a multi-cycle SRAM handshake from the MEM stage. From these it drives the freeze/flush inputs of the IF, ID, EXE and MEM pipeline registers and the SRAM start strobe. It also keeps saturating stall/flush performance counters and a sticky memory-timeout error flag.

---
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates the MEM-stage SRAM wait,
// EXE taken branches and ID hazards, and keeps saturating performance counters.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             B_EXE,
  input  logic             mem_req,
  input  logic             sram_done,
  output logic             freeze_IF,
  output logic             freeze_ID,
  output logic             freeze_EXE,
  output logic             freeze_MEM,
  output logic             flush_IF,
  output logic             flush_ID,
  output logic             branch_taken,
  output logic             hazard_bubble,
  output logic             sram_start,
  output logic             mem_err,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0]       WCNT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             hz_inc, mw_inc, fl_inc, err_set;
  logic [CNT_W-1:0] hazard_cnt_q, mem_wait_cnt_q, flush_cnt_q;
  logic             mem_err_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    freeze_IF     = 1'b0;
    freeze_ID     = 1'b0;
    freeze_EXE    = 1'b0;
    freeze_MEM    = 1'b0;
    flush_IF      = 1'b0;
    flush_ID      = 1'b0;
    branch_taken  = 1'b0;
    hazard_bubble = 1'b0;
    sram_start    = 1'b0;
    hz_inc        = 1'b0;
    mw_inc        = 1'b0;
    fl_inc        = 1'b0;
    err_set       = 1'b0;

    if (!rst) begin
      case (state_q)
        RUN: begin
          if (mem_req) begin
            freeze_IF  = 1'b1;
            freeze_ID  = 1'b1;
            freeze_EXE = 1'b1;
            freeze_MEM = 1'b1;
            sram_start = 1'b1;
            state_d    = MEM_WAIT;
            wcnt_d     = '0;
          end else if (B_EXE) begin
            // A flush wins over a hazard stall: the stalled instruction is squashed anyway.
            flush_IF     = 1'b1;
            flush_ID     = 1'b1;
            branch_taken = 1'b1;
            fl_inc       = 1'b1;
          end else if (hazard) begin
            freeze_IF     = 1'b1;
            hazard_bubble = 1'b1;
            hz_inc        = 1'b1;
          end
        end
        MEM_WAIT: begin
          mw_inc = 1'b1;
          if (sram_done) begin
            state_d = RUN;
          end else if (wcnt_q == WCNT_LAST) begin
            state_d = RUN;
            err_set = 1'b1;
          end else begin
            freeze_IF  = 1'b1;
            freeze_ID  = 1'b1;
            freeze_EXE = 1'b1;
            freeze_MEM = 1'b1;
            wcnt_d     = wcnt_q + 8'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every one samples pre-edge values.
    if (rst) begin
      state_q        <= RUN;
      wcnt_q         <= '0;
      hazard_cnt_q   <= '0;
      mem_wait_cnt_q <= '0;
      flush_cnt_q    <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (hz_inc && hazard_cnt_q != CNT_MAX)   hazard_cnt_q   <= hazard_cnt_q + CNT_W'(1);
      if (mw_inc && mem_wait_cnt_q != CNT_MAX) mem_wait_cnt_q <= mem_wait_cnt_q + CNT_W'(1);
      if (fl_inc && flush_cnt_q != CNT_MAX)    flush_cnt_q    <= flush_cnt_q + CNT_W'(1);
      if (err_set)                             mem_err_q      <= 1'b1;
    end
  end

  assign hazard_cnt   = hazard_cnt_q;
  assign mem_wait_cnt = mem_wait_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table and corner sequences on a small instance,
// then random stimulus on a small and a default instance against a cycle-level model.
module tb_pipeline_ctrl;

  localparam int TA = 5;
  localparam int CA = 4;
  localparam int TB_T = 15;
  localparam int CB = 16;

  // {freeze_IF, freeze_ID, freeze_EXE, freeze_MEM, flush_IF, flush_ID, branch_taken, hazard_bubble, sram_start}
  localparam logic [8:0] Z     = 9'b0000_000_0_0;
  localparam logic [8:0] HZ    = 9'b1000_000_1_0;
  localparam logic [8:0] MEMF  = 9'b1111_000_0_1;
  localparam logic [8:0] WAITF = 9'b1111_000_0_0;
  localparam logic [8:0] BR    = 9'b0000_111_0_0;

  logic clk = 1'b0;
  logic rst = 1'b1, hazard = 1'b0, B_EXE = 1'b0, mem_req = 1'b0, sram_done = 1'b0;

  logic a_fif, a_fid, a_fexe, a_fmem, a_flif, a_flid, a_bt, a_hb, a_ss, a_err;
  logic b_fif, b_fid, b_fexe, b_fmem, b_flif, b_flid, b_bt, b_hb, b_ss, b_err;
  logic [CA-1:0] a_hcnt, a_wcnt, a_fcnt;
  logic [CB-1:0] b_hcnt, b_wcnt, b_fcnt;
  logic [8:0] a_ctrl, b_ctrl;

  assign a_ctrl = {a_fif, a_fid, a_fexe, a_fmem, a_flif, a_flid, a_bt, a_hb, a_ss};
  assign b_ctrl = {b_fif, b_fid, b_fexe, b_fmem, b_flif, b_flid, b_bt, b_hb, b_ss};

  pipeline_ctrl #(.MEM_TIMEOUT(TA), .CNT_W(CA)) dut_a (
    .clk(clk), .rst(rst), .hazard(hazard), .B_EXE(B_EXE), .mem_req(mem_req),
    .sram_done(sram_done), .freeze_IF(a_fif), .freeze_ID(a_fid), .freeze_EXE(a_fexe),
    .freeze_MEM(a_fmem), .flush_IF(a_flif), .flush_ID(a_flid), .branch_taken(a_bt),
    .hazard_bubble(a_hb), .sram_start(a_ss), .mem_err(a_err), .hazard_cnt(a_hcnt),
    .mem_wait_cnt(a_wcnt), .flush_cnt(a_fcnt)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(TB_T), .CNT_W(CB)) dut_b (
    .clk(clk), .rst(rst), .hazard(hazard), .B_EXE(B_EXE), .mem_req(mem_req),
    .sram_done(sram_done), .freeze_IF(b_fif), .freeze_ID(b_fid), .freeze_EXE(b_fexe),
    .freeze_MEM(b_fmem), .flush_IF(b_flif), .flush_ID(b_flid), .branch_taken(b_bt),
    .hazard_bubble(b_hb), .sram_start(b_ss), .mem_err(b_err), .hazard_cnt(b_hcnt),
    .mem_wait_cnt(b_wcnt), .flush_cnt(b_fcnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         r, h, b, m, d;
    logic [8:0] ctrl;
    int         hc, wc, fc;
    bit         err;
  } vec_t;

  function automatic vec_t v(input bit r, h, b, m, d, input logic [8:0] ctrl,
                             input int hc, wc, fc, input bit err);
    vec_t t;
    t.r = r; t.h = h; t.b = b; t.m = m; t.d = d;
    t.ctrl = ctrl; t.hc = hc; t.wc = wc; t.fc = fc; t.err = err;
    return t;
  endfunction

  // Drive one cycle of inputs, compare dut_a mid-cycle, then advance past the edge.
  task automatic apply(input vec_t t, input string tag);
    rst = t.r; hazard = t.h; B_EXE = t.b; mem_req = t.m; sram_done = t.d;
    @(negedge clk);
    check({tag, " ctrl"}, 32'(a_ctrl), 32'(t.ctrl));
    check({tag, " hazard_cnt"}, 32'(a_hcnt), t.hc);
    check({tag, " mem_wait_cnt"}, 32'(a_wcnt), t.wc);
    check({tag, " flush_cnt"}, 32'(a_fcnt), t.fc);
    check({tag, " mem_err"}, 32'(a_err), 32'(t.err));
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks whether a memory access is outstanding and how many
  // wait cycles have elapsed, with counters as plain saturating integers.
  typedef struct {
    bit waiting;
    int waited;
    int hc, wc, fc;
    bit err;
  } mdl_t;

  mdl_t ma, mb;

  function automatic int sat_inc(input int x, input int mx);
    return (x < mx) ? x + 1 : x;
  endfunction

  function automatic logic [8:0] m_out(input mdl_t m, input int tmo, input bit r, h, b, mq, d);
    if (r) return Z;
    if (!m.waiting) begin
      if (mq) return MEMF;
      if (b) return BR;
      if (h) return HZ;
      return Z;
    end
    if (d || (m.waited + 1 == tmo)) return Z;
    return WAITF;
  endfunction

  function automatic mdl_t m_step(input mdl_t m, input int tmo, input int mx,
                                  input bit r, h, b, mq, d);
    mdl_t n = m;
    if (r) begin
      n.waiting = 0; n.waited = 0; n.hc = 0; n.wc = 0; n.fc = 0; n.err = 0;
    end else if (!m.waiting) begin
      if (mq) begin
        n.waiting = 1;
        n.waited = 0;
      end else if (b) n.fc = sat_inc(m.fc, mx);
      else if (h) n.hc = sat_inc(m.hc, mx);
    end else begin
      n.wc = sat_inc(m.wc, mx);
      if (d) n.waiting = 0;
      else if (m.waited + 1 == tmo) begin
        n.waiting = 0;
        n.err = 1;
      end else n.waited = m.waited + 1;
    end
    return n;
  endfunction

  vec_t tbl[$];

  initial begin
    // Initial unchecked reset cycle so all counters start from a known value.
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset with all inputs high, hazard stall, 4-cycle SRAM access, branch held during a wait,
    // back-to-back accesses, flush over hazard, mem_req over hazard, done ignored in RUN.
    tbl.push_back(v(1,1,1,1,1, Z,     0, 0,0,0));
    tbl.push_back(v(1,1,1,1,1, Z,     0, 0,0,0));
    tbl.push_back(v(0,0,0,0,0, Z,     0, 0,0,0));
    tbl.push_back(v(0,1,0,0,0, HZ,    0, 0,0,0));
    tbl.push_back(v(0,1,0,0,0, HZ,    1, 0,0,0));
    tbl.push_back(v(0,1,0,0,0, HZ,    2, 0,0,0));
    tbl.push_back(v(0,0,0,0,0, Z,     3, 0,0,0));
    tbl.push_back(v(0,0,0,1,0, MEMF,  3, 0,0,0));
    tbl.push_back(v(0,0,0,1,0, WAITF, 3, 0,0,0));
    tbl.push_back(v(0,0,0,1,0, WAITF, 3, 1,0,0));
    tbl.push_back(v(0,0,0,1,0, WAITF, 3, 2,0,0));
    tbl.push_back(v(0,0,0,1,1, Z,     3, 3,0,0));
    tbl.push_back(v(0,0,0,0,0, Z,     3, 4,0,0));
    tbl.push_back(v(0,0,1,1,0, MEMF,  3, 4,0,0));
    tbl.push_back(v(0,0,1,1,0, WAITF, 3, 4,0,0));
    tbl.push_back(v(0,0,1,1,0, WAITF, 3, 5,0,0));
    tbl.push_back(v(0,0,1,1,1, Z,     3, 6,0,0));
    tbl.push_back(v(0,0,1,0,0, BR,    3, 7,0,0));
    tbl.push_back(v(0,0,0,0,0, Z,     3, 7,1,0));
    tbl.push_back(v(0,0,0,1,0, MEMF,  3, 7,1,0));
    tbl.push_back(v(0,0,0,1,1, Z,     3, 7,1,0));
    tbl.push_back(v(0,0,0,1,0, MEMF,  3, 8,1,0));
    tbl.push_back(v(0,0,0,1,1, Z,     3, 8,1,0));
    tbl.push_back(v(0,1,1,0,0, BR,    3, 9,1,0));
    tbl.push_back(v(0,1,0,1,0, MEMF,  3, 9,2,0));
    tbl.push_back(v(0,1,0,1,1, Z,     3, 9,2,0));
    tbl.push_back(v(0,0,0,0,1, Z,     3,10,2,0));
    tbl.push_back(v(0,0,0,0,0, Z,     3,10,2,0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Timeout (MEM_TIMEOUT=5): freezes drop in the 5th wait cycle, sticky error after;
    // mem_wait_cnt also reaches its 4-bit ceiling here and must hold.
    apply(v(0,0,0,1,0, MEMF,  3,10,2,0), "tmo start");
    apply(v(0,0,0,1,0, WAITF, 3,10,2,0), "tmo w1");
    apply(v(0,0,0,1,0, WAITF, 3,11,2,0), "tmo w2");
    apply(v(0,0,0,1,0, WAITF, 3,12,2,0), "tmo w3");
    apply(v(0,0,0,1,0, WAITF, 3,13,2,0), "tmo w4");
    apply(v(0,0,0,1,0, Z,     3,14,2,0), "tmo w5");
    apply(v(0,0,0,0,0, Z,     3,15,2,1), "tmo err");
    apply(v(0,0,0,1,0, MEMF,  3,15,2,1), "tmo again");
    apply(v(0,0,0,1,1, Z,     3,15,2,1), "tmo done");
    apply(v(0,0,0,0,0, Z,     3,15,2,1), "tmo sticky");

    // Reset clears the error; reset in the middle of a wait aborts it without an error.
    apply(v(1,0,0,0,0, Z,     3,15,2,1), "rst1");
    apply(v(0,0,0,1,0, MEMF,  0, 0,0,0), "rst start");
    apply(v(0,0,0,1,0, WAITF, 0, 0,0,0), "rst wait");
    apply(v(1,0,0,1,0, Z,     0, 1,0,0), "rst mid");
    apply(v(0,0,0,0,0, Z,     0, 0,0,0), "rst after");
    apply(v(0,0,0,1,0, MEMF,  0, 0,0,0), "rst restart");
    apply(v(0,0,0,1,1, Z,     0, 0,0,0), "rst done");

    // Hazard held 20 cycles: the 4-bit counter stops at 15, the 16-bit one reaches 20.
    for (int k = 0; k < 20; k++)
      apply(v(0,1,0,0,0, HZ, (k < 15) ? k : 15, 1,0,0), $sformatf("sat[%0d]", k));
    apply(v(0,0,0,0,0, Z, 15, 1,0,0), "sat end");
    check("sat wide hazard_cnt", 32'(b_hcnt), 20);
    check("sat wide mem_err", 32'(b_err), 0);

    // Random phase on both instances against the model.
    rst = 1'b1; hazard = 1'b0; B_EXE = 1'b0; mem_req = 1'b0; sram_done = 1'b0;
    @(posedge clk);
    #1;
    ma = '{default: 0};
    mb = '{default: 0};
    for (int i = 0; i < 2000; i++) begin
      bit r, h, b, mq, d;
      int dprob;
      dprob = ((i / 250) % 2 == 1) ? 12 : 3;
      r  = ($urandom_range(0, 59) == 0);
      h  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 3) == 0);
      mq = ($urandom_range(0, 3) == 0);
      d  = ($urandom_range(0, dprob - 1) == 0);
      rst = r; hazard = h; B_EXE = b; mem_req = mq; sram_done = d;
      @(negedge clk);
      check($sformatf("rnd[%0d] a ctrl", i), 32'(a_ctrl), 32'(m_out(ma, TA, r, h, b, mq, d)));
      check($sformatf("rnd[%0d] a hazard_cnt", i), 32'(a_hcnt), ma.hc);
      check($sformatf("rnd[%0d] a mem_wait_cnt", i), 32'(a_wcnt), ma.wc);
      check($sformatf("rnd[%0d] a flush_cnt", i), 32'(a_fcnt), ma.fc);
      check($sformatf("rnd[%0d] a mem_err", i), 32'(a_err), 32'(ma.err));
      check($sformatf("rnd[%0d] b ctrl", i), 32'(b_ctrl), 32'(m_out(mb, TB_T, r, h, b, mq, d)));
      check($sformatf("rnd[%0d] b hazard_cnt", i), 32'(b_hcnt), mb.hc);
      check($sformatf("rnd[%0d] b mem_wait_cnt", i), 32'(b_wcnt), mb.wc);
      check($sformatf("rnd[%0d] b flush_cnt", i), 32'(b_fcnt), mb.fc);
      check($sformatf("rnd[%0d] b mem_err", i), 32'(b_err), 32'(mb.err));
      ma = m_step(ma, TA, (1 << CA) - 1, r, h, b, mq, d);
      mb = m_step(mb, TB_T, (1 << CB) - 1, r, h, b, mq, d);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
